// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   arb_state_e  : arbiter sequencing states
//   PORT_DCACHE  : port index of the data-cache controller
//   PORT_IFETCH  : port index of the instruction-fetch refill path
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic PORT_DCACHE = 1'b0;
    localparam logic PORT_IFETCH = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   pend[1:0] in  : per-port pending flags
//   last      in  : port granted most recently
//   valid     out : at least one port pending
//   winner    out : port to grant (meaningful only when valid)
module rr_pick2
    import sram_arb_pkg::*;
(
    input  logic [1:0] pend,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |pend;
        winner = PORT_DCACHE;
        if (pend == 2'b11) begin
            // contention: the port that did not go last wins
            winner = ~last;
        end else if (pend[PORT_IFETCH]) begin
            winner = PORT_IFETCH;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between the data cache (port 0) and the
// instruction refill path (port 1). One request is latched at a time,
// driven through the SRAM enable/ready handshake, and completed with a
// one-cycle ready pulse to the owning port, followed by one release cycle
// with both enables low.
//   clk, rst             : clock, asynchronous active-low reset
//   reqN_read/write      : port N request (held until reqN_ready)
//   reqN_address/wdata   : port N address / write data
//   reqN_ready           : port N completion pulse
//   rdata                : read data, valid in the reqN_ready cycle
//   sram_read/write_en   : enables to the SRAM controller
//   sram_address/wdata   : address / write data to the SRAM controller
//   sram_rdata           : read data from the SRAM controller
//   sram_ready           : done pulse from the SRAM controller
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WDATA_W = 32,
    parameter int unsigned RDATA_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_read,
    input  logic               req0_write,
    input  logic [ADDR_W-1:0]  req0_address,
    input  logic [WDATA_W-1:0] req0_wdata,
    output logic               req0_ready,
    input  logic               req1_read,
    input  logic               req1_write,
    input  logic [ADDR_W-1:0]  req1_address,
    input  logic [WDATA_W-1:0] req1_wdata,
    output logic               req1_ready,
    output logic [RDATA_W-1:0] rdata,
    output logic               sram_read_en,
    output logic               sram_write_en,
    output logic [ADDR_W-1:0]  sram_address,
    output logic [WDATA_W-1:0] sram_wdata,
    input  logic [RDATA_W-1:0] sram_rdata,
    input  logic               sram_ready
);

    arb_state_e         state;
    arb_state_e         next_state;
    logic               owner;
    logic               last;
    logic               op_write;
    logic               op_read;
    logic [ADDR_W-1:0]  addr_q;
    logic [WDATA_W-1:0] wdata_q;

    logic [1:0]         pend;
    logic               pick_valid;
    logic               pick_winner;
    logic               grant;
    logic               sel_read;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_address;
    logic [WDATA_W-1:0] sel_wdata;

    assign pend = {req1_read | req1_write, req0_read | req0_write};

    rr_pick2 u_pick (
        .pend   (pend),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign grant       = (state == IDLE) && pick_valid;
    assign sel_read    = (pick_winner == PORT_IFETCH) ? req1_read    : req0_read;
    assign sel_write   = (pick_winner == PORT_IFETCH) ? req1_write   : req0_write;
    assign sel_address = (pick_winner == PORT_IFETCH) ? req1_address : req0_address;
    assign sel_wdata   = (pick_winner == PORT_IFETCH) ? req1_wdata   : req0_wdata;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid) next_state = BUSY;
            BUSY:    if (sram_ready) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction registers: requester inputs are sampled only at grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= PORT_DCACHE;
            last     <= PORT_IFETCH;
            op_write <= 1'b0;
            op_read  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (grant) begin
            owner    <= pick_winner;
            last     <= pick_winner;
            // read and write together is treated as a write
            op_write <= sel_write;
            op_read  <= sel_read & ~sel_write;
            addr_q   <= sel_address;
            wdata_q  <= sel_wdata;
        end
    end

    // Outputs: everything is quiet outside BUSY, so a mid-transaction
    // reset drops the enables and suppresses any ready pulse at once
    always_comb begin
        sram_read_en  = 1'b0;
        sram_write_en = 1'b0;
        sram_address  = '0;
        sram_wdata    = '0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        rdata         = '0;
        if (state == BUSY) begin
            sram_read_en  = op_read;
            sram_write_en = op_write;
            sram_address  = addr_q;
            sram_wdata    = wdata_q;
            if (sram_ready) begin
                rdata      = sram_rdata;
                req0_ready = (owner == PORT_DCACHE);
                req1_ready = (owner == PORT_IFETCH);
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WDATA_W = 32;
    localparam int unsigned RDATA_W = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               req0_read, req0_write, req1_read, req1_write;
    logic [ADDR_W-1:0]  req0_address, req1_address;
    logic [WDATA_W-1:0] req0_wdata, req1_wdata;
    logic               req0_ready, req1_ready;
    logic [RDATA_W-1:0] rdata;
    logic               sram_read_en, sram_write_en;
    logic [ADDR_W-1:0]  sram_address;
    logic [WDATA_W-1:0] sram_wdata;
    logic [RDATA_W-1:0] sram_rdata;
    logic               sram_ready;
    logic               resp_ready, force_ready;

    assign sram_ready = resp_ready | force_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // SRAM controller behaviour knobs
    int          lat       = 3;
    bit          spurious  = 1'b0;
    bit          fixed_en  = 1'b0;
    logic [63:0] fixed_val = '0;

    sram_arbiter #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_read     (req0_read),
        .req0_write    (req0_write),
        .req0_address  (req0_address),
        .req0_wdata    (req0_wdata),
        .req0_ready    (req0_ready),
        .req1_read     (req1_read),
        .req1_write    (req1_write),
        .req1_address  (req1_address),
        .req1_wdata    (req1_wdata),
        .req1_ready    (req1_ready),
        .rdata         (rdata),
        .sram_read_en  (sram_read_en),
        .sram_write_en (sram_write_en),
        .sram_address  (sram_address),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .sram_ready    (sram_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM controller: ready after `lat` cycles of an enable being high
    initial begin : sram_model
        int busy_cnt;
        busy_cnt   = 0;
        resp_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sram_read_en || sram_write_en) begin
                busy_cnt++;
                resp_ready = (busy_cnt >= lat);
                if (resp_ready) busy_cnt = 0;
            end else begin
                busy_cnt   = 0;
                resp_ready = spurious && ($urandom_range(0, 3) == 0);
            end
            sram_rdata = fixed_en ? fixed_val : {$urandom, $urandom};
        end
    end

    // Transaction-level reference: one optional in-flight transaction,
    // a pending one-cycle gap after completion, and the last granted port.
    bit          m_active, m_gap, m_last, m_owner, m_read, m_write;
    logic [31:0] m_addr, m_wdata;

    always @(negedge clk) begin : ref_model
        bit p0, p1, w, er0, er1;
        if (!rst) begin
            m_active = 0; m_gap = 0; m_last = 1; m_owner = 0;
            m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0;
            check("reset_ctl", 64'({sram_read_en, sram_write_en, req0_ready, req1_ready}), 64'(0));
            check("reset_addr_wdata", {sram_address, sram_wdata}, 64'(0));
            check("reset_rdata", rdata, 64'(0));
        end else begin
            er0 = m_active && sram_ready && !m_owner;
            er1 = m_active && sram_ready && m_owner;
            check("enables", 64'({sram_read_en, sram_write_en}),
                  64'({m_active && m_read, m_active && m_write}));
            check("ready", 64'({req1_ready, req0_ready}), 64'({er1, er0}));
            if (m_active) check("addr_wdata", {sram_address, sram_wdata}, {m_addr, m_wdata});
            if (er0 || er1) check("rdata", rdata, sram_rdata);
            // what happens at the coming rising edge
            if (m_active) begin
                if (sram_ready) begin
                    m_active = 0;
                    m_gap    = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                p0 = req0_read || req0_write;
                p1 = req1_read || req1_write;
                if (p0 || p1) begin
                    w        = (p0 && p1) ? !m_last : p1;
                    m_owner  = w;
                    m_last   = w;
                    m_write  = w ? req1_write : req0_write;
                    m_read   = (w ? req1_read : req0_read) && !m_write;
                    m_addr   = w ? req1_address : req0_address;
                    m_wdata  = w ? req1_wdata : req0_wdata;
                    m_active = 1;
                end
            end
        end
    end

    task automatic clear_reqs();
        req0_read = 0; req0_write = 0; req0_address = '0; req0_wdata = '0;
        req1_read = 0; req1_write = 0; req1_address = '0; req1_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = sram_read_en || sram_write_en;
        end
        check(name, 64'(got), 64'(1));
    endtask

    task automatic wait_rdy(input string name, input int port, output bit other,
                            output logic [63:0] rd);
        bit got;
        got = 0; other = 0; rd = '0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? req1_ready : req0_ready) other = 1;
            if ((port == 0) ? req0_ready : req1_ready) begin
                got = 1;
                rd  = rdata;
            end
        end
        check(name, 64'(got), 64'(1));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin : stimulus
        bit          other;
        logic [63:0] rd;
        logic [5:0]  seq;
        logic [2:0]  gap_en;
        int          cnt, pulses;

        clear_reqs();
        force_ready = 0;

        // reset held with random inputs
        repeat (4) begin
            step();
            {req0_read, req0_write, req1_read, req1_write} = 4'($urandom);
            req0_address = $urandom; req1_address = $urandom;
            req0_wdata = $urandom; req1_wdata = $urandom;
            force_ready = 1'($urandom);
            #1;
            check("reset_held_outputs",
                  64'({sram_read_en, sram_write_en, req0_ready, req1_ready, rdata != 0,
                       sram_address != 0, sram_wdata != 0}), 64'(0));
        end
        step();
        force_ready = 0;
        clear_reqs();
        rst = 1;

        // only port 1 reads after reset: enable rises after the grant edge
        req1_read = 1; req1_address = 32'h200;
        #1 check("pre_grant_read_en", 64'(sram_read_en), 64'(0));
        step();
        check("first_grant_read_en", 64'(sram_read_en), 64'(1));
        wait_rdy("first_grant_ready", 1, other, rd);
        step();
        clear_reqs();

        // single write, held to check the gap and the re-grant
        lat = 5;
        req0_write = 1; req0_address = 32'h0000_0040; req0_wdata = 32'hDEAD_BEEF;
        wait_en("write_enable_timeout");
        check("write_ctl", 64'({sram_write_en, sram_read_en}), 64'(2));
        check("write_addr", 64'(sram_address), 64'(32'h40));
        check("write_wdata", 64'(sram_wdata), 64'(32'hDEAD_BEEF));
        cnt = 1;
        while (!req0_ready && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("write_latency", 64'(cnt), 64'(5));
        @(negedge clk); gap_en[2] = sram_write_en | sram_read_en; pulses = int'(req0_ready);
        @(negedge clk); gap_en[1] = sram_write_en | sram_read_en;
        @(negedge clk); gap_en[0] = sram_write_en | sram_read_en;
        check("release_gap_then_regrant", 64'(gap_en), 64'(3'b001));
        check("single_ready_pulse", 64'(pulses), 64'(0));
        wait_rdy("regrant_ready", 0, other, rd);
        step();
        clear_reqs();

        // read return on port 1
        lat = 2; fixed_en = 1; fixed_val = 64'h1122_3344_5566_7788;
        req1_read = 1; req1_address = 32'h100;
        wait_rdy("read_ready", 1, other, rd);
        check("read_rdata", rd, 64'h1122_3344_5566_7788);
        check("read_no_port0_ready", 64'(other), 64'(0));
        step();
        clear_reqs();
        fixed_en = 0;

        // both ports read continuously: strict alternation from port 0
        lat = 1;
        step();
        req0_read = 1; req0_address = 32'h10;
        req1_read = 1; req1_address = 32'h20;
        seq = '0;
        for (int k = 0; k < 6; k++) begin
            bit got;
            got = 0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got    = 1;
                    seq[k] = req1_ready;
                end
            end
            check("tie_ready_timeout", 64'(got), 64'(1));
        end
        check("tie_order", 64'(seq), 64'(6'b101010));
        step();
        clear_reqs();

        // read+write together is a write
        lat = 3;
        step();
        req0_read = 1; req0_write = 1; req0_address = 32'h80; req0_wdata = 32'h5A5A_0001;
        wait_en("rw_enable_timeout");
        check("rw_is_write", 64'({sram_write_en, sram_read_en}), 64'(2));
        wait_rdy("rw_ready", 0, other, rd);
        step();
        clear_reqs();

        // withdrawn request still completes
        lat = 4;
        step();
        req1_read = 1; req1_address = 32'h300;
        wait_en("withdraw_enable_timeout");
        step();
        req1_read = 0;
        wait_rdy("withdraw_ready", 1, other, rd);
        step();

        // asynchronous reset between grant and sram_ready
        lat = 10;
        req0_write = 1; req0_address = 32'h44; req0_wdata = 32'h1234_5678;
        wait_en("midbusy_enable_timeout");
        @(posedge clk);
        #3 rst = 0;
        #1;
        check("midbusy_reset_ctl", 64'({sram_read_en, sram_write_en, req0_ready, req1_ready}), 64'(0));
        check("midbusy_reset_addr", {sram_address, sram_wdata}, 64'(0));
        clear_reqs();
        @(posedge clk);
        #3 rst = 1;
        step();
        force_ready = 1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(req0_ready) + int'(req1_ready);
        end
        force_ready = 0;
        check("no_ready_after_reset", 64'(pulses), 64'(0));

        // randomized traffic with spurious readies and occasional resets
        spurious = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) lat = $urandom_range(1, 4);
            if ($urandom_range(0, 2) == 0) begin
                {req0_read, req0_write} = 2'($urandom);
                req0_address = $urandom; req0_wdata = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                {req1_read, req1_write} = 2'($urandom);
                req1_address = $urandom; req1_wdata = $urandom;
            end
            if (i % 750 == 300) begin
                #2 rst = 0;
                @(posedge clk);
                #3 rst = 1;
            end
        end
        spurious = 0;
        step();
        clear_reqs();
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
